// File: rtl/icache_plru_burst.sv
// N-way set-associative read-only instruction cache with registered lookup,
// burst line refill, tree-PLRU replacement (invalid ways first) and whole-cache flush.
module icache_plru_burst #(
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  output logic                  cpu_ready_o,
  output logic                  cpu_valid_o,
  output logic [WORD_WIDTH-1:0] cpu_inst_o,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_valid_i,
  input  logic [WORD_WIDTH-1:0] mem_data_i
);
  localparam int BEATS    = LINE_WIDTH / WORD_WIDTH;
  localparam int OFF_W    = $clog2(BEATS);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int TAG_W    = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam int LINE_LSB = OFF_W + 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP, FLUSH} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-3:0] req_word;
  logic [OFF_W-1:0]      req_off;
  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  unused_addr_bits;

  logic [TAG_W-1:0]      tag_mem  [NUM_SETS][NUM_WAYS];
  logic [WORD_WIDTH-1:0] data_mem [NUM_SETS][NUM_WAYS][BEATS];
  logic [NUM_WAYS-1:0]   valid_q  [NUM_SETS];
  logic [NUM_WAYS-2:0]   plru_q   [NUM_SETS];
  logic [WORD_WIDTH-1:0] fill_buf [BEATS];
  logic [OFF_W-1:0]      beat_cnt;
  logic                  flush_pending;

  logic                  hit, multi_hit, accept, refill_last;
  logic [WAY_W-1:0]      hit_way, victim;

  assign req_off          = req_word[OFF_W-1:0];
  assign req_idx          = req_word[OFF_W +: IDX_W];
  assign req_tag          = req_word[ADDR_WIDTH-3 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign accept           = cpu_req_i && cpu_ready_o;
  assign refill_last      = (state == REFILL) && mem_valid_i && (beat_cnt == OFF_W'(BEATS - 1));

  // Each tree node on the path to the touched way is set to point at the other subtree.
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                     input logic [WAY_W-1:0]    way);
    logic [NUM_WAYS-2:0] b;
    int node;
    b    = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b[node] = ~way[WAY_W-1-l];
      node    = 2 * node + 1 + int'(way[WAY_W-1-l]);
    end
    return b;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    logic [WAY_W-1:0] v;
    int node;
    v    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      v    = (v << 1) | WAY_W'(bits[node]);
      node = 2 * node + 1 + int'(bits[node]);
    end
    return v;
  endfunction

  always_comb begin
    hit       = 1'b0;
    multi_hit = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        if (hit) multi_hit = 1'b1;
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-index invalid way overrides the PLRU choice.
  always_comb begin
    victim = plru_victim(plru_q[req_idx]);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    state_nxt   = state;
    cpu_ready_o = 1'b0;
    cpu_valid_o = 1'b0;
    cpu_inst_o  = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    case (state)
      IDLE: begin
        if (flush_i || flush_pending) begin
          state_nxt = FLUSH;
        end else begin
          cpu_ready_o = rst_n;
          if (cpu_req_i) state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          cpu_valid_o = 1'b1;
          cpu_inst_o  = data_mem[req_idx][hit_way][req_off];
          cpu_ready_o = 1'b1;
          if (!cpu_req_i) state_nxt = IDLE;
        end else begin
          state_nxt = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_word[ADDR_WIDTH-3:OFF_W], LINE_LSB'(0)};
        if (mem_gnt_i) state_nxt = REFILL;
      end
      REFILL: begin
        if (refill_last) state_nxt = RESP;
      end
      RESP: begin
        cpu_valid_o = 1'b1;
        cpu_inst_o  = fill_buf[req_off];
        state_nxt   = IDLE;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, flush bookkeeping, beat counter, valid and PLRU bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      beat_cnt      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (flush_i && (state != IDLE)) flush_pending <= 1'b1;
      else if (state == FLUSH)        flush_pending <= 1'b0;
      if (state == MISS_REQ)                    beat_cnt <= '0;
      else if ((state == REFILL) && mem_valid_i) beat_cnt <= beat_cnt + OFF_W'(1);
      if (state == FLUSH) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_q[s] <= '0;
          plru_q[s]  <= '0;
        end
      end else if ((state == LOOKUP) && hit) begin
        plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
      end else if (refill_last) begin
        valid_q[req_idx][victim] <= 1'b1;
        plru_q[req_idx]          <= plru_touch(plru_q[req_idx], victim);
      end
    end
  end

  // Datapath storage: latched request, fill buffer, tag and line arrays.
  always_ff @(posedge clk) begin
    if (accept) req_word <= cpu_addr_i[ADDR_WIDTH-1:2];
    if ((state == REFILL) && mem_valid_i) fill_buf[beat_cnt] <= mem_data_i;
    if (refill_last) begin
      tag_mem[req_idx][victim] <= req_tag;
      for (int b = 0; b < BEATS; b++) begin
        data_mem[req_idx][victim][b] <= (b == BEATS - 1) ? mem_data_i : fill_buf[b];
      end
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
                                 (state == LOOKUP) |-> !multi_hit);

endmodule

// File: tb/tb_icache_plru_burst.sv
// Directed bench for icache_plru_burst: cold miss, streaming hits, PLRU eviction,
// flush in IDLE and during refill, reset mid-refill, simultaneous flush and request.
module tb_icache_plru_burst;
  logic        clk;
  logic        rst_n;
  logic        cpu_req_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_ready_o;
  logic        cpu_valid_o;
  logic [31:0] cpu_inst_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;

  int vectors = 0;
  int errs    = 0;

  icache_plru_burst #(
    .LINE_WIDTH(128), .WORD_WIDTH(32), .NUM_WAYS(4), .NUM_SETS(64), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_ready_o(cpu_ready_o),
    .cpu_valid_o(cpu_valid_o), .cpu_inst_o(cpu_inst_o), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request in an IDLE cycle; it is accepted at the following rising edge.
  task automatic accept(input logic [31:0] addr);
    @(negedge clk);
    cpu_req_i  = 1'b1;
    cpu_addr_i = addr;
    #1;
    chk("accept_ready", cpu_ready_o, 1);
  endtask

  // Miss path from LOOKUP through RESP; beat b of the line carries base+b.
  task automatic miss_fill(input logic [31:0] line, input logic [31:0] base,
                           input int off, input bit flush_mid);
    @(negedge clk);
    cpu_req_i = 1'b0;
    #1;
    chk("miss_valid", cpu_valid_o, 0);
    chk("miss_ready", cpu_ready_o, 0);
    @(negedge clk);
    mem_valid_i = 1'b1;
    mem_data_i  = 32'hDEAD_BEEF;
    #1;
    chk("mem_req", mem_req_o, 1);
    chk("mem_addr", mem_addr_o, line);
    @(negedge clk);
    mem_valid_i = 1'b0;
    mem_gnt_i   = 1'b1;
    #1;
    chk("mem_req_held", mem_req_o, 1);
    chk("mem_addr_held", mem_addr_o, line);
    @(negedge clk);
    mem_gnt_i   = 1'b0;
    mem_valid_i = 1'b1;
    mem_data_i  = base;
    #1;
    chk("mem_req_refill", mem_req_o, 0);
    @(negedge clk);
    mem_data_i = base + 32'd1;
    flush_i    = flush_mid;
    @(negedge clk);
    flush_i     = 1'b0;
    mem_valid_i = 1'b0;
    @(negedge clk);
    mem_valid_i = 1'b1;
    mem_data_i  = base + 32'd2;
    @(negedge clk);
    mem_data_i = base + 32'd3;
    @(negedge clk);
    mem_valid_i = 1'b0;
    #1;
    chk("resp_valid", cpu_valid_o, 1);
    chk("resp_inst", cpu_inst_o, base + 32'(off));
    chk("resp_ready", cpu_ready_o, 0);
  endtask

  task automatic hit1(input logic [31:0] addr, input logic [31:0] exp);
    accept(addr);
    @(negedge clk);
    cpu_req_i = 1'b0;
    #1;
    chk("hit_valid", cpu_valid_o, 1);
    chk("hit_inst", cpu_inst_o, exp);
    chk("hit_no_mem", mem_req_o, 0);
  endtask

  task automatic flush_idle();
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_ready", cpu_ready_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_state_ready", cpu_ready_o, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_addr_i  = '0;
    flush_i     = 1'b0;
    mem_gnt_i   = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i  = '0;

    @(negedge clk);
    #1;
    chk("rst_ready", cpu_ready_o, 0);
    chk("rst_valid", cpu_valid_o, 0);
    chk("rst_inst", cpu_inst_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", cpu_ready_o, 1);

    // Cold miss on 0x1004: refill line 0x1000, respond with word 1.
    accept(32'h0000_1004);
    miss_fill(32'h0000_1000, 32'hA000_0000, 1, 1'b0);
    @(negedge clk);
    #1;
    chk("idle_after_resp_valid", cpu_valid_o, 0);
    chk("idle_after_resp_ready", cpu_ready_o, 1);

    // Streaming hits 0x1000, 0x1008, 0x100C on consecutive cycles.
    @(negedge clk);
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h0000_1000;
    #1;
    chk("stream_ready0", cpu_ready_o, 1);
    @(negedge clk);
    cpu_addr_i = 32'h0000_1008;
    #1;
    chk("stream_valid0", cpu_valid_o, 1);
    chk("stream_inst0", cpu_inst_o, 32'hA000_0000);
    chk("stream_ready1", cpu_ready_o, 1);
    chk("stream_no_mem0", mem_req_o, 0);
    @(negedge clk);
    cpu_addr_i = 32'h0000_100C;
    #1;
    chk("stream_valid1", cpu_valid_o, 1);
    chk("stream_inst1", cpu_inst_o, 32'hA000_0002);
    @(negedge clk);
    cpu_req_i = 1'b0;
    #1;
    chk("stream_valid2", cpu_valid_o, 1);
    chk("stream_inst2", cpu_inst_o, 32'hA000_0003);
    chk("stream_no_mem2", mem_req_o, 0);
    @(negedge clk);
    #1;
    chk("stream_end_valid", cpu_valid_o, 0);
    chk("stream_end_inst", cpu_inst_o, 0);

    // Flush in IDLE: 0x1004 misses again and picks up new line data.
    flush_idle();
    accept(32'h0000_1004);
    miss_fill(32'h0000_1000, 32'hB000_0000, 1, 1'b0);

    // Eviction: fill all four ways of set 0, then 0x1000 replaces way 0 (0x0000).
    flush_idle();
    accept(32'h0000_0000);
    miss_fill(32'h0000_0000, 32'hC000_0000, 0, 1'b0);
    accept(32'h0000_0400);
    miss_fill(32'h0000_0400, 32'hC100_0000, 0, 1'b0);
    accept(32'h0000_0800);
    miss_fill(32'h0000_0800, 32'hC200_0000, 0, 1'b0);
    accept(32'h0000_0C00);
    miss_fill(32'h0000_0C00, 32'hC300_0000, 0, 1'b0);
    hit1(32'h0000_0C04, 32'hC300_0001);
    accept(32'h0000_1000);
    miss_fill(32'h0000_1000, 32'hD000_0000, 0, 1'b0);
    hit1(32'h0000_0404, 32'hC100_0001);
    hit1(32'h0000_100C, 32'hD000_0003);
    accept(32'h0000_0000);
    miss_fill(32'h0000_0000, 32'hE000_0000, 0, 1'b0);

    // Flush during refill: response still delivered, then FLUSH, then the line misses.
    accept(32'h0000_2008);
    miss_fill(32'h0000_2000, 32'h2000_0000, 2, 1'b1);
    @(negedge clk);
    #1;
    chk("pending_idle_ready", cpu_ready_o, 0);
    @(negedge clk);
    #1;
    chk("pending_flush_ready", cpu_ready_o, 0);
    accept(32'h0000_2008);
    miss_fill(32'h0000_2000, 32'h2100_0000, 2, 1'b0);

    // Reset in the middle of a refill of line 0x3000, with 0x1000 cached beforehand.
    accept(32'h0000_1004);
    miss_fill(32'h0000_1000, 32'hF000_0000, 1, 1'b0);
    hit1(32'h0000_1004, 32'hF000_0001);
    accept(32'h0000_3000);
    @(negedge clk);
    cpu_req_i = 1'b0;
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i   = 1'b0;
    mem_valid_i = 1'b1;
    mem_data_i  = 32'h3000_0000;
    @(negedge clk);
    mem_data_i = 32'h3000_0001;
    @(negedge clk);
    mem_data_i = 32'h3000_0002;
    @(negedge clk);
    mem_valid_i = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("midrst_ready", cpu_ready_o, 0);
    chk("midrst_valid", cpu_valid_o, 0);
    chk("midrst_inst", cpu_inst_o, 0);
    chk("midrst_mem_req", mem_req_o, 0);
    chk("midrst_mem_addr", mem_addr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", cpu_ready_o, 1);
    accept(32'h0000_1004);
    miss_fill(32'h0000_1000, 32'h1200_0000, 1, 1'b0);

    // Flush and request together in IDLE: flush first, request accepted afterwards.
    @(negedge clk);
    flush_i    = 1'b1;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h0000_1004;
    #1;
    chk("simul_ready", cpu_ready_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("simul_flush_ready", cpu_ready_o, 0);
    chk("simul_flush_valid", cpu_valid_o, 0);
    @(negedge clk);
    #1;
    chk("simul_accept_ready", cpu_ready_o, 1);
    miss_fill(32'h0000_1000, 32'h1300_0000, 1, 1'b0);
    @(negedge clk);
    #1;
    chk("final_idle_valid", cpu_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
